// File: rtl/yellowball_sprite_fetch.sv
// Pixel-fetch stage for the yellowball sprite: scan position -> sprite ROM address -> palette index.
// Two-stage pipeline; the ball position is sampled once per frame so the sprite never tears.
module yellowball_sprite_fetch #(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter int         ADDR_W      = 8,
    parameter int         SCALE_LOG2  = 0,
    parameter logic [7:0] TRANS_INDEX = 8'd5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_sync,
    input  logic              display_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        BallX,
    input  logic [9:0]        BallY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic [7:0]        palette_index,
    output logic              pixel_on
);

    localparam int          COL_BITS = $clog2(SPRITE_W);
    localparam logic [10:0] BOX_W    = 11'(SPRITE_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H    = 11'(SPRITE_H << SCALE_LOG2);

    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic [10:0]       col;
    logic [10:0]       row;
    logic              inbox;
    logic [ADDR_W-1:0] addr_next;
    logic              v1;
    logic              opaque;

    // The 11-bit differences carry a sign bit, so a sprite hanging off the
    // right edge can never wrap around to column 0 of the same line.
    always_comb begin
        dx        = {1'b0, DrawX} - {1'b0, pos_x};
        dy        = {1'b0, DrawY} - {1'b0, pos_y};
        inbox     = display_en && !dx[10] && (dx < BOX_W) && !dy[10] && (dy < BOX_H);
        col       = dx >> SCALE_LOG2;
        row       = dy >> SCALE_LOG2;
        addr_next = '0;
        if (inbox) begin
            addr_next = ADDR_W'((32'(row) << COL_BITS) | 32'(col));
        end
        opaque    = v1 && (rom_q != TRANS_INDEX);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x         <= '0;
            pos_y         <= '0;
            rom_addr      <= '0;
            v1            <= 1'b0;
            pixel_on      <= 1'b0;
            palette_index <= '0;
        end else begin
            if (frame_sync) begin
                pos_x <= BallX;
                pos_y <= BallY;
            end
            rom_addr      <= addr_next;
            v1            <= inbox;
            pixel_on      <= opaque;
            palette_index <= opaque ? rom_q : 8'd0;
        end
    end

endmodule

// File: tb/tb_yellowball_sprite_fetch.sv
// Directed bench for yellowball_sprite_fetch: a 1x instance fed by a q=addr ROM,
// plus a 2x-scaled instance whose ball position is left at its reset value.
module tb_yellowball_sprite_fetch;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_sync = 1'b0;
    logic       frame_sync_s = 1'b0;
    logic       display_en = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [9:0] BallX = '0;
    logic [9:0] BallY = '0;
    logic [7:0] rom_addr;
    logic [7:0] rom_q;
    logic [7:0] palette_index;
    logic       pixel_on;
    logic [7:0] rom_addr_s;
    logic [7:0] rom_q_s;
    logic [7:0] palette_index_s;
    logic       pixel_on_s;
    logic       trans_mode = 1'b0;

    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    // ROM content model: word value equals its address, or all-transparent.
    assign rom_q   = trans_mode ? 8'd5 : rom_addr;
    assign rom_q_s = rom_addr_s;

    yellowball_sprite_fetch u_dut (
        .Clk(Clk), .Reset(Reset), .frame_sync(frame_sync), .display_en(display_en),
        .DrawX(DrawX), .DrawY(DrawY), .BallX(BallX), .BallY(BallY),
        .rom_addr(rom_addr), .rom_q(rom_q), .palette_index(palette_index), .pixel_on(pixel_on)
    );

    yellowball_sprite_fetch #(.SCALE_LOG2(1)) u_scale (
        .Clk(Clk), .Reset(Reset), .frame_sync(frame_sync_s), .display_en(display_en),
        .DrawX(DrawX), .DrawY(DrawY), .BallX(BallX), .BallY(BallY),
        .rom_addr(rom_addr_s), .rom_q(rom_q_s), .palette_index(palette_index_s), .pixel_on(pixel_on_s)
    );

    task automatic applyStimulus(input int x, input int y, input logic en, input logic fs, input logic rst);
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        display_en = en;
        frame_sync = fs;
        Reset      = rst;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        BallX = 10'd100;
        BallY = 10'd50;
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (rom_addr !== 8'd0 || palette_index !== 8'd0 || pixel_on !== 1'b0)
            $display("[TB] FAIL reset_outputs: got addr=%0d idx=%0d on=%0b expected 0/0/0", rom_addr, palette_index, pixel_on);
        else passes++;
        checks++;
        if (rom_addr_s !== 8'd0 || palette_index_s !== 8'd0 || pixel_on_s !== 1'b0)
            $display("[TB] FAIL reset_outputs_scaled: got addr=%0d idx=%0d on=%0b expected 0/0/0", rom_addr_s, palette_index_s, pixel_on_s);
        else passes++;
        // Reset beat the coincident frame_sync, so the sprite sits at (0,0).
        applyStimulus(3, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixel_on !== 1'b1 || palette_index !== 8'd3)
            $display("[TB] FAIL reset_wins_over_sync: got on=%0b idx=%0d expected 1/3", pixel_on, palette_index);
        else passes++;
    endtask

    task automatic test_scale();
        int ex;
        for (int x = 0; x <= 35; x++) begin
            applyStimulus(x, 3, (x <= 34), 1'b0, 1'b0);
            ex = (x < 32) ? 16 + (x >> 1) : 0;
            checks++;
            if (rom_addr_s !== 8'(ex))
                $display("[TB] FAIL scale_addr x=%0d: got %0d expected %0d", x, rom_addr_s, ex);
            else passes++;
            if (x > 0) begin
                ex = (x - 1 < 32) ? 16 + ((x - 1) >> 1) : 0;
                checks++;
                if (pixel_on_s !== (x - 1 < 32) || palette_index_s !== 8'(ex))
                    $display("[TB] FAIL scale_pixel x=%0d: got on=%0b idx=%0d expected on=%0b idx=%0d",
                             x - 1, pixel_on_s, palette_index_s, (x - 1 < 32), ex);
                else passes++;
            end
        end
    endtask

    task automatic test_sweep();
        int  ea;
        int  px;
        logic eon;
        BallX = 10'd100;
        BallY = 10'd50;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        for (int x = 95; x <= 121; x++) begin
            applyStimulus(x, 50, (x <= 120), 1'b0, 1'b0);
            ea = (x >= 100 && x <= 115) ? x - 100 : 0;
            checks++;
            if (rom_addr !== 8'(ea))
                $display("[TB] FAIL sweep_addr x=%0d: got %0d expected %0d", x, rom_addr, ea);
            else passes++;
            if (x > 95) begin
                px  = x - 1;
                eon = (px >= 100 && px <= 115 && px != 105);
                checks++;
                if (pixel_on !== eon || palette_index !== (eon ? 8'(px - 100) : 8'd0))
                    $display("[TB] FAIL sweep_pixel x=%0d: got on=%0b idx=%0d expected on=%0b idx=%0d",
                             px, pixel_on, palette_index, eon, eon ? px - 100 : 0);
                else passes++;
            end
        end
    endtask

    task automatic test_latch();
        BallX = 10'd200;
        applyStimulus(102, 50, 1'b1, 1'b0, 1'b0);
        applyStimulus(202, 50, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pixel_on !== 1'b1 || palette_index !== 8'd2)
            $display("[TB] FAIL latch_hold_old: got on=%0b idx=%0d expected 1/2", pixel_on, palette_index);
        else passes++;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixel_on !== 1'b0)
            $display("[TB] FAIL latch_no_new: got on=%0b expected 0", pixel_on);
        else passes++;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(102, 50, 1'b1, 1'b0, 1'b0);
        applyStimulus(202, 50, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pixel_on !== 1'b0)
            $display("[TB] FAIL latch_old_gone: got on=%0b expected 0", pixel_on);
        else passes++;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixel_on !== 1'b1 || palette_index !== 8'd2)
            $display("[TB] FAIL latch_moved: got on=%0b idx=%0d expected 1/2", pixel_on, palette_index);
        else passes++;
    endtask

    task automatic test_clip();
        int   px [$];
        int   py [$];
        logic pe [$];
        int   cx;
        logic eon;
        BallX = 10'd630;
        BallY = 10'd50;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        for (int x = 628; x <= 650; x++) begin px.push_back(x); py.push_back(50); pe.push_back(x <= 639); end
        for (int x = 0; x <= 5; x++)     begin px.push_back(x); py.push_back(51); pe.push_back(1'b1); end
        px.push_back(0); py.push_back(0); pe.push_back(1'b0);
        for (int i = 0; i < px.size(); i++) begin
            applyStimulus(px[i], py[i], pe[i], 1'b0, 1'b0);
            if (i > 0) begin
                cx  = px[i-1];
                eon = pe[i-1] && py[i-1] == 50 && cx >= 630 && cx != 635;
                checks++;
                if (pixel_on !== eon || palette_index !== (eon ? 8'(cx - 630) : 8'd0))
                    $display("[TB] FAIL clip_pixel x=%0d y=%0d: got on=%0b idx=%0d expected on=%0b idx=%0d",
                             cx, py[i-1], pixel_on, palette_index, eon, eon ? cx - 630 : 0);
                else passes++;
            end
        end
    endtask

    task automatic test_mid_reset();
        BallX = 10'd100;
        BallY = 10'd50;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(100, 50, 1'b1, 1'b0, 1'b0);
        applyStimulus(101, 50, 1'b1, 1'b0, 1'b0);
        applyStimulus(102, 50, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pixel_on !== 1'b1 || palette_index !== 8'd1)
            $display("[TB] FAIL midreset_before: got on=%0b idx=%0d expected 1/1", pixel_on, palette_index);
        else passes++;
        applyStimulus(103, 50, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pixel_on !== 1'b0 || palette_index !== 8'd0 || rom_addr !== 8'd0)
            $display("[TB] FAIL midreset_cleared: got on=%0b idx=%0d addr=%0d expected 0/0/0", pixel_on, palette_index, rom_addr);
        else passes++;
        for (int x = 104; x <= 110; x++) begin
            applyStimulus(x, 50, 1'b1, 1'b0, 1'b0);
            checks++;
            if (pixel_on !== 1'b0 || palette_index !== 8'd0)
                $display("[TB] FAIL midreset_absent x=%0d: got on=%0b idx=%0d expected 0/0", x, pixel_on, palette_index);
            else passes++;
        end
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(102, 50, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixel_on !== 1'b1 || palette_index !== 8'd2)
            $display("[TB] FAIL midreset_restored: got on=%0b idx=%0d expected 1/2", pixel_on, palette_index);
        else passes++;
    endtask

    task automatic test_transparent();
        trans_mode = 1'b1;
        for (int y = 50; y <= 51; y++) begin
            for (int x = 100; x <= 117; x++) begin
                applyStimulus(x, y, (x <= 115), 1'b0, 1'b0);
                checks++;
                if (pixel_on !== 1'b0 || palette_index !== 8'd0)
                    $display("[TB] FAIL transparent x=%0d y=%0d: got on=%0b idx=%0d expected 0/0", x, y, pixel_on, palette_index);
                else passes++;
            end
        end
        trans_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scale();
        test_sweep();
        test_latch();
        test_clip();
        test_mid_reset();
        test_transparent();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
